// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter_pkg : shared widths, FSM/grant encodings and transfer record
//                       for the MEM/IF to SRAM-slave bus arbiter.
// Revision: 1.0
// ============================================================================
package mem_bus_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_BUSY = 1'b1;

    localparam logic [0:0] ARB_M0 = 1'b0;
    localparam logic [0:0] ARB_M1 = 1'b1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xfer_t;

    // Fetch wins only when MEM is idle or fetch has waited out its starvation budget.
    function automatic logic pick_m1(input logic m0_req,
                                     input logic m1_req,
                                     input logic starve_full);
        return m1_req && (!m0_req || starve_full);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_watchdog.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter_watchdog : counts BUSY cycles and flags the last permitted
//                            cycle of a transfer that has not been acked.
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int            CW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q holds the number of BUSY cycles already completed, so expiry is
    // raised during the TIMEOUT_CYC-th BUSY cycle and acted on at its end.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter : two-master (MEM stage, instruction fetch) to one SRAM
//                   slave arbiter with starvation guard and transfer watchdog.
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int STARVE_LIM  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_data_o,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic              bus_select_o,
    output logic              bus_we_o,
    input  logic              bus_ack_i,
    output logic              bus_err_o
);

    localparam int            SW         = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    logic [0:0]        state_q,    state_d;
    logic [0:0]        grant_q,    grant_d;
    xfer_t             xfer_q,     xfer_d;
    logic [SW-1:0]     starve_q,   starve_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              m0_ack_q,   m0_ack_d;
    logic              m1_ack_q,   m1_ack_d;
    logic              err_q,      err_d;

    logic              in_idle;
    logic              in_busy;
    logic              starve_full;
    logic              grant_m0;
    logic              grant_m1;
    logic              wd_expired;
    logic              done;
    logic [DATA_W-1:0] done_data;

    assign in_idle     = (state_q == ARB_IDLE);
    assign in_busy     = (state_q == ARB_BUSY);
    assign starve_full = (starve_q == STARVE_MAX);
    assign grant_m1    = in_idle && pick_m1(m0_req, m1_req, starve_full);
    assign grant_m0    = in_idle && m0_req && !grant_m1;

    // Slave ack takes precedence over a watchdog expiry in the same cycle.
    assign done        = in_busy && (bus_ack_i || wd_expired);
    assign done_data   = bus_ack_i ? bus_data_i : '0;

    mem_bus_arbiter_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (grant_m0 || grant_m1),
        .enable_i  (in_busy),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        xfer_d     = xfer_q;
        starve_d   = starve_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        m0_ack_d   = 1'b0;
        m1_ack_d   = 1'b0;
        err_d      = 1'b0;

        if (!m1_req || grant_m1) begin
            starve_d = '0;
        end else if (grant_m0 && !starve_full) begin
            starve_d = starve_q + 1'b1;
        end

        if (grant_m1) begin
            state_d      = ARB_BUSY;
            grant_d      = ARB_M1;
            xfer_d.we    = 1'b0;
            xfer_d.addr  = m1_addr;
            xfer_d.wdata = '0;
        end else if (grant_m0) begin
            state_d      = ARB_BUSY;
            grant_d      = ARB_M0;
            xfer_d.we    = m0_we;
            xfer_d.addr  = m0_addr;
            xfer_d.wdata = m0_wdata;
        end

        if (done) begin
            state_d = ARB_IDLE;
            err_d   = !bus_ack_i;
            if (grant_q == ARB_M1) begin
                m1_rdata_d = done_data;
                m1_ack_d   = 1'b1;
            end else begin
                m0_rdata_d = done_data;
                m0_ack_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= ARB_M0;
            xfer_q     <= '0;
            starve_q   <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            xfer_q     <= xfer_d;
            starve_q   <= starve_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            err_q      <= err_d;
        end
    end

    assign bus_select_o = in_busy;
    assign bus_addr_o   = xfer_q.addr;
    assign bus_data_o   = xfer_q.wdata;
    assign bus_we_o     = xfer_q.we;
    assign bus_err_o    = err_q;
    assign m0_rdata     = m0_rdata_q;
    assign m0_ack       = m0_ack_q;
    assign m1_rdata     = m1_rdata_q;
    assign m1_ack       = m1_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_bus_arbiter : self-checking bench for mem_bus_arbiter with a slave
//                      model, bus monitor and transaction-level scoreboard.
// Revision: 1.0
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int TIMEOUT_CYC = 64;
    localparam int STARVE_LIM  = 4;
    localparam int WAIT_MAX    = 400;
    localparam int N_RAND      = 25;

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic        m0_req   = 1'b0;
    logic        m0_we    = 1'b0;
    logic [31:0] m0_addr  = '0;
    logic [31:0] m0_wdata = '0;
    logic [31:0] m0_rdata;
    logic        m0_ack;
    logic        m1_req   = 1'b0;
    logic [31:0] m1_addr  = '0;
    logic [31:0] m1_rdata;
    logic        m1_ack;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_data_o;
    logic [31:0] bus_data_i = '0;
    logic        bus_select_o;
    logic        bus_we_o;
    logic        bus_ack_i  = 1'b0;
    logic        bus_err_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .STARVE_LIM  (STARVE_LIM)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m0_req       (m0_req),
        .m0_we        (m0_we),
        .m0_addr      (m0_addr),
        .m0_wdata     (m0_wdata),
        .m0_rdata     (m0_rdata),
        .m0_ack       (m0_ack),
        .m1_req       (m1_req),
        .m1_addr      (m1_addr),
        .m1_rdata     (m1_rdata),
        .m1_ack       (m1_ack),
        .bus_addr_o   (bus_addr_o),
        .bus_data_o   (bus_data_o),
        .bus_data_i   (bus_data_i),
        .bus_select_o (bus_select_o),
        .bus_we_o     (bus_we_o),
        .bus_ack_i    (bus_ack_i),
        .bus_err_o    (bus_err_o)
    );

    // ---------------- slave model: acks after slave_delay select cycles -----
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rdata;
    } slv_rec_t;

    int          slave_delay = 2;   // 0 = never ack, -1 = random 1..4
    logic        spurious    = 1'b0;
    logic        use_fixed   = 1'b0;
    logic [31:0] fixed_data  = '0;
    slv_rec_t    slave_log[$];

    initial begin
        int busy_cnt  = 0;
        int cur_delay = 0;
        forever begin
            @(posedge clk); #1;
            bus_ack_i = 1'b0;
            if (bus_select_o) begin
                busy_cnt++;
                if (busy_cnt == 1)
                    cur_delay = (slave_delay < 0) ? int'($urandom_range(1, 4)) : slave_delay;
                if (cur_delay != 0 && busy_cnt == cur_delay) begin
                    bus_data_i = use_fixed ? fixed_data : $urandom;
                    bus_ack_i  = 1'b1;
                    slave_log.push_back('{bus_addr_o, bus_data_o, bus_we_o, bus_data_i});
                end
            end else begin
                busy_cnt = 0;
                if (spurious) begin
                    bus_ack_i  = 1'b1;
                    bus_data_i = $urandom;
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } grant_rec_t;

    grant_rec_t grant_log[$];
    int last_busy_len = 0;
    int m0_ack_cnt    = 0;
    int m1_ack_cnt    = 0;
    int err_cnt       = 0;
    int both_cnt      = 0;
    int unstable_cnt  = 0;

    initial begin
        logic       prev_sel = 1'b0;
        int         cur_len  = 0;
        grant_rec_t cur_g;
        cur_g = '{1'b0, 32'h0, 32'h0};
        forever begin
            @(posedge clk); #1;
            if (bus_select_o && !prev_sel) begin
                cur_g = '{bus_we_o, bus_addr_o, bus_data_o};
                grant_log.push_back(cur_g);
                cur_len = 1;
            end else if (bus_select_o) begin
                cur_len++;
                if (bus_we_o !== cur_g.we || bus_addr_o !== cur_g.addr || bus_data_o !== cur_g.wdata)
                    unstable_cnt++;
            end else if (prev_sel) begin
                last_busy_len = cur_len;
            end
            prev_sel = bus_select_o;
            if (m0_ack) m0_ack_cnt++;
            if (m1_ack) m1_ack_cnt++;
            if (bus_err_o) err_cnt++;
            if (m0_ack && m1_ack) both_cnt++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1);
    end

    // ---------------- master drivers (called at posedge+1) ----------------
    task automatic m0_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           output logic got, output logic [31:0] rdata, output logic err,
                           output int cyc);
        m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_req = 1'b1; cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!m0_ack && cyc < WAIT_MAX);
        got = m0_ack; rdata = m0_rdata; err = bus_err_o;
        m0_req = 1'b0;
    endtask

    task automatic m1_xfer(input logic [31:0] addr,
                           output logic got, output logic [31:0] rdata, output logic err,
                           output int cyc);
        m1_addr = addr; m1_req = 1'b1; cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!m1_ack && cyc < WAIT_MAX);
        got = m1_ack; rdata = m1_rdata; err = bus_err_o;
        m1_req = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        idle_cycles(2);
        total_cnt++;
        if ({bus_addr_o, bus_data_o, bus_select_o, bus_we_o, bus_err_o} !== '0)
            $display("FAIL reset_bus_outputs: got %h/%h sel=%b we=%b err=%b, want all 0",
                     bus_addr_o, bus_data_o, bus_select_o, bus_we_o, bus_err_o);
        else pass_cnt++;
        total_cnt++;
        if ({m0_rdata, m0_ack, m1_rdata, m1_ack} !== '0)
            $display("FAIL reset_master_outputs: got m0=%h/%b m1=%h/%b, want all 0",
                     m0_rdata, m0_ack, m1_rdata, m1_ack);
        else pass_cnt++;
        rst = 1'b1;
        idle_cycles(2);
        total_cnt++;
        if (bus_select_o !== 1'b0) $display("FAIL reset_release_idle: sel=%b, want 0", bus_select_o);
        else pass_cnt++;
    endtask

    task automatic test_idle_ack();
        int a0 = m0_ack_cnt, a1 = m1_ack_cnt;
        spurious = 1'b1;
        idle_cycles(6);
        spurious = 1'b0;
        idle_cycles(2);
        total_cnt++;
        if ((m0_ack_cnt - a0) + (m1_ack_cnt - a1) != 0 || m0_rdata !== 32'h0 || m1_rdata !== 32'h0)
            $display("FAIL idle_ack_ignored: acks=%0d m0_rdata=%h m1_rdata=%h, want 0/0/0",
                     (m0_ack_cnt - a0) + (m1_ack_cnt - a1), m0_rdata, m1_rdata);
        else pass_cnt++;
    endtask

    task automatic test_m0_write();
        logic got, err; logic [31:0] rd; int cyc;
        int a0 = m0_ack_cnt, a1 = m1_ack_cnt;
        slv_rec_t rec;
        slave_log.delete();
        slave_delay = 2;
        m0_xfer(1'b1, 32'h0000_0010, 32'hA5A5_1234, got, rd, err, cyc);
        total_cnt++;
        if (got !== 1'b1 || cyc != 3 || err !== 1'b0)
            $display("FAIL m0_write_ack: got=%b cyc=%0d err=%b, want 1/3/0", got, cyc, err);
        else pass_cnt++;
        total_cnt++;
        if (slave_log.size() != 1) $display("FAIL m0_write_slave_count: got %0d, want 1", slave_log.size());
        else pass_cnt++;
        rec = (slave_log.size() > 0) ? slave_log.pop_front() : '{32'h0, 32'h0, 1'b0, 32'h0};
        total_cnt++;
        if (rec.we !== 1'b1 || rec.addr !== 32'h0000_0010 || rec.wdata !== 32'hA5A5_1234)
            $display("FAIL m0_write_bus: we=%b addr=%h data=%h, want 1/00000010/a5a51234",
                     rec.we, rec.addr, rec.wdata);
        else pass_cnt++;
        total_cnt++;
        if (rd !== rec.rdata) $display("FAIL m0_write_rdata: got %h, want %h", rd, rec.rdata);
        else pass_cnt++;
        idle_cycles(2);
        total_cnt++;
        if (m0_ack_cnt - a0 != 1 || m1_ack_cnt - a1 != 0 || last_busy_len != 2)
            $display("FAIL m0_write_pulses: m0_acks=%0d m1_acks=%0d busy=%0d, want 1/0/2",
                     m0_ack_cnt - a0, m1_ack_cnt - a1, last_busy_len);
        else pass_cnt++;
    endtask

    task automatic test_m1_fetch();
        logic got, err; logic [31:0] rd; int cyc;
        slv_rec_t rec;
        slave_log.delete();
        slave_delay = 2; use_fixed = 1'b1; fixed_data = 32'h2402_0001;
        m1_xfer(32'h0000_0100, got, rd, err, cyc);
        use_fixed = 1'b0;
        total_cnt++;
        if (got !== 1'b1 || cyc != 3 || rd !== 32'h2402_0001)
            $display("FAIL m1_fetch: got=%b cyc=%0d rdata=%h, want 1/3/24020001", got, cyc, rd);
        else pass_cnt++;
        rec = (slave_log.size() > 0) ? slave_log.pop_front() : '{32'h0, 32'hFFFF_FFFF, 1'b1, 32'h0};
        total_cnt++;
        if (rec.we !== 1'b0 || rec.wdata !== 32'h0 || rec.addr !== 32'h0000_0100 || unstable_cnt != 0)
            $display("FAIL m1_fetch_bus: we=%b data=%h addr=%h unstable=%0d, want 0/0/00000100/0",
                     rec.we, rec.wdata, rec.addr, unstable_cnt);
        else pass_cnt++;
        idle_cycles(1);
    endtask

    logic starve_stop;

    task automatic test_starve();
        int base = grant_log.size();
        int starve = 0;
        starve_stop = 1'b0;
        slave_delay = -1;
        fork
            begin
                logic g, e; logic [31:0] r; int c;
                while (!starve_stop) begin
                    m0_xfer(1'($urandom), {16'h0000, 16'($urandom)}, $urandom, g, r, e, c);
                    if (!g) begin
                        total_cnt++;
                        $display("FAIL starve_m0_wait: no ack within %0d cycles", c);
                        break;
                    end
                end
            end
            begin
                logic g, e; logic [31:0] r; int c;
                while (!starve_stop) begin
                    m1_xfer({16'h8000, 16'($urandom)}, g, r, e, c);
                    if (!g) begin
                        total_cnt++;
                        $display("FAIL starve_m1_wait: no ack within %0d cycles", c);
                        break;
                    end
                end
            end
            begin
                int w = 0;
                while (grant_log.size() < base + 15 && w < 2000) begin @(posedge clk); #1; w++; end
                starve_stop = 1'b1;
            end
        join
        idle_cycles(2);
        total_cnt++;
        if (grant_log.size() < base + 15)
            $display("FAIL starve_grant_count: got %0d, want >= 15", grant_log.size() - base);
        else begin
            pass_cnt++;
            // Both masters always pending: m1 owed a grant once m0 has won STARVE_LIM times.
            for (int i = 0; i < 15; i++) begin
                logic exp_m1, act_m1;
                exp_m1 = (starve == STARVE_LIM);
                act_m1 = grant_log[base + i].addr[31];
                total_cnt++;
                if (act_m1 !== exp_m1)
                    $display("FAIL starve_order[%0d]: got m%0d, want m%0d", i, act_m1, exp_m1);
                else pass_cnt++;
                starve = exp_m1 ? 0 : starve + 1;
            end
        end
        slave_log.delete();
    endtask

    task automatic test_timeout();
        logic got, err; logic [31:0] rd; int cyc;
        int e0;
        slave_log.delete();
        slave_delay = 1; use_fixed = 1'b1; fixed_data = 32'hDEAD_BEEF;
        m0_xfer(1'b0, 32'h0000_0044, 32'h0, got, rd, err, cyc);
        total_cnt++;
        if (got !== 1'b1 || rd !== 32'hDEAD_BEEF || cyc != 2)
            $display("FAIL timeout_setup_read: got=%b rdata=%h cyc=%0d, want 1/deadbeef/2", got, rd, cyc);
        else pass_cnt++;
        use_fixed = 1'b0;
        slave_delay = 0;
        e0 = err_cnt;
        m0_xfer(1'b0, 32'h0000_0048, 32'h0, got, rd, err, cyc);
        total_cnt++;
        if (got !== 1'b1 || err !== 1'b1 || rd !== 32'h0 || cyc != TIMEOUT_CYC + 1)
            $display("FAIL timeout_abort: ack=%b err=%b rdata=%h cyc=%0d, want 1/1/0/%0d",
                     got, err, rd, cyc, TIMEOUT_CYC + 1);
        else pass_cnt++;
        idle_cycles(2);
        total_cnt++;
        if (last_busy_len != TIMEOUT_CYC || err_cnt - e0 != 1)
            $display("FAIL timeout_select_len: busy=%0d errs=%0d, want %0d/1",
                     last_busy_len, err_cnt - e0, TIMEOUT_CYC);
        else pass_cnt++;
    endtask

    task automatic test_ack_at_expiry();
        logic got, err; logic [31:0] rd; int cyc;
        int e0 = err_cnt;
        slave_delay = TIMEOUT_CYC; use_fixed = 1'b1; fixed_data = 32'h1234_5678;
        m1_xfer(32'h0000_0200, got, rd, err, cyc);
        use_fixed = 1'b0;
        total_cnt++;
        if (got !== 1'b1 || err !== 1'b0 || rd !== 32'h1234_5678 || cyc != TIMEOUT_CYC + 1)
            $display("FAIL ack_at_expiry: ack=%b err=%b rdata=%h cyc=%0d, want 1/0/12345678/%0d",
                     got, err, rd, cyc, TIMEOUT_CYC + 1);
        else pass_cnt++;
        idle_cycles(2);
        total_cnt++;
        if (err_cnt != e0 || last_busy_len != TIMEOUT_CYC)
            $display("FAIL ack_at_expiry_err: errs=%0d busy=%0d, want 0/%0d",
                     err_cnt - e0, last_busy_len, TIMEOUT_CYC);
        else pass_cnt++;
        slave_log.delete();
    endtask

    task automatic test_async_reset();
        logic got, err; logic [31:0] rd; int cyc;
        int a0 = m0_ack_cnt;
        int w = 0;
        slave_delay = 0;
        m0_we = 1'b0; m0_addr = 32'h0000_0080; m0_req = 1'b1;
        while (!bus_select_o && w < 10) begin @(posedge clk); #1; w++; end
        total_cnt++;
        if (bus_select_o !== 1'b1) $display("FAIL areset_busy_entry: sel=%b, want 1", bus_select_o);
        else pass_cnt++;
        idle_cycles(3);
        #2 rst = 1'b0;
        #1;
        total_cnt++;
        if (bus_select_o !== 1'b0 || m0_ack !== 1'b0 || m1_ack !== 1'b0 || bus_err_o !== 1'b0)
            $display("FAIL areset_async_drop: sel=%b m0_ack=%b m1_ack=%b err=%b, want 0/0/0/0",
                     bus_select_o, m0_ack, m1_ack, bus_err_o);
        else pass_cnt++;
        m0_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_cycles(3);
        total_cnt++;
        if (bus_select_o !== 1'b0 || m0_ack_cnt != a0)
            $display("FAIL areset_idle_after: sel=%b m0_acks=%0d, want 0/0", bus_select_o, m0_ack_cnt - a0);
        else pass_cnt++;
        slave_log.delete();
        slave_delay = 2; use_fixed = 1'b1; fixed_data = 32'hCAFE_0001;
        m1_xfer(32'h0000_0300, got, rd, err, cyc);
        use_fixed = 1'b0;
        total_cnt++;
        if (got !== 1'b1 || rd !== 32'hCAFE_0001 || cyc != 3)
            $display("FAIL areset_fresh_req: ack=%b rdata=%h cyc=%0d, want 1/cafe0001/3", got, rd, cyc);
        else pass_cnt++;
        slave_log.delete();
    endtask

    task automatic test_random();
        int a0 = m0_ack_cnt, a1 = m1_ack_cnt, e0 = err_cnt;
        slave_log.delete();
        slave_delay = -1;
        fork
            begin
                logic g, e, we; logic [31:0] r, addr, wd; int c;
                slv_rec_t rec;
                for (int i = 0; i < N_RAND; i++) begin
                    idle_cycles($urandom_range(0, 3));
                    we = 1'($urandom); addr = {16'h0000, 16'($urandom)}; wd = $urandom;
                    m0_xfer(we, addr, wd, g, r, e, c);
                    total_cnt++;
                    if (!g || e !== 1'b0 || slave_log.size() == 0)
                        $display("FAIL rand_m0_done[%0d]: ack=%b err=%b log=%0d, want 1/0/>0",
                                 i, g, e, slave_log.size());
                    else begin
                        rec = slave_log.pop_front();
                        if (rec.addr !== addr || rec.we !== we || rec.wdata !== wd || r !== rec.rdata)
                            $display("FAIL rand_m0_data[%0d]: bus %h/%b/%h rdata %h, want %h/%b/%h rdata %h",
                                     i, rec.addr, rec.we, rec.wdata, r, addr, we, wd, rec.rdata);
                        else pass_cnt++;
                    end
                end
            end
            begin
                logic g, e; logic [31:0] r, addr; int c;
                slv_rec_t rec;
                for (int i = 0; i < N_RAND; i++) begin
                    idle_cycles($urandom_range(0, 3));
                    addr = {16'h8000, 16'($urandom)};
                    m1_xfer(addr, g, r, e, c);
                    total_cnt++;
                    if (!g || e !== 1'b0 || slave_log.size() == 0)
                        $display("FAIL rand_m1_done[%0d]: ack=%b err=%b log=%0d, want 1/0/>0",
                                 i, g, e, slave_log.size());
                    else begin
                        rec = slave_log.pop_front();
                        if (rec.addr !== addr || rec.we !== 1'b0 || rec.wdata !== 32'h0 || r !== rec.rdata)
                            $display("FAIL rand_m1_data[%0d]: bus %h/%b/%h rdata %h, want %h/0/0 rdata %h",
                                     i, rec.addr, rec.we, rec.wdata, r, addr, rec.rdata);
                        else pass_cnt++;
                    end
                end
            end
        join
        idle_cycles(2);
        total_cnt++;
        if (m0_ack_cnt - a0 != N_RAND || m1_ack_cnt - a1 != N_RAND || err_cnt != e0)
            $display("FAIL rand_ack_totals: m0=%0d m1=%0d errs=%0d, want %0d/%0d/0",
                     m0_ack_cnt - a0, m1_ack_cnt - a1, err_cnt - e0, N_RAND, N_RAND);
        else pass_cnt++;
        total_cnt++;
        if (both_cnt != 0 || unstable_cnt != 0)
            $display("FAIL rand_invariants: both_acks=%0d unstable=%0d, want 0/0", both_cnt, unstable_cnt);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_idle_ack();
        test_m0_write();
        test_m1_fetch();
        test_starve();
        test_timeout();
        test_ack_at_expiry();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
